// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch stage.
//   if_state_e       : fetch FSM states (FETCH, SKID, DRAIN)
//   NOP_INSTR        : value held in IF/ID after reset
//   OPCODE_MSB/LSB   : opcode field position inside the instruction word
//   RESET_PC_DEFAULT : default PC after reset
//   PC_STEP_DEFAULT  : default byte increment per sequential fetch
// ----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 26;
    localparam int          OPCODE_W         = OPCODE_MSB - OPCODE_LSB + 1;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

    // Sequential PC advance; 32-bit add wraps modulo 2^32.
    function automatic logic [31:0] pc_advance(input logic [31:0] pc,
                                               input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// ----------------------------------------------------------------------------
// if_skid_buf
// One-entry holding register for a fetched word that arrived while IF/ID was
// full and stalled. Stores the instruction and its pc_plus4.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : capture instr_i / pc_plus4_i, entry becomes valid
//   drain_i       : entry has been moved into IF/ID, becomes empty
//   clear_i       : discard entry (redirect); highest priority
//   instr_i       : instruction word to capture
//   pc_plus4_i    : address of that word + step
//   valid_o       : entry holds a word
//   instr_o       : held instruction word
//   pc_plus4_o    : held pc_plus4
// ----------------------------------------------------------------------------
module if_skid_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
        end else if (clear_i) begin
            valid_q    <= 1'b0;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
        end else if (drain_i) begin
            valid_q    <= 1'b0;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// presents the fetched word in the IF/ID register feeding the control unit.
// Handles downstream stall (one-entry skid buffer), branch redirect, and
// draining of a request that was in flight when a branch arrived.
//
// Handshake: imem_req/imem_addr are registered; once imem_req is high it stays
// high with imem_addr unchanged until a cycle with imem_ack=1, which completes
// the request with imem_rdata valid in that same cycle. IF/ID is consumed on
// a rising edge where instr_valid=1 and stall=0.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   imem_req         : fetch request
//   imem_addr        : fetch address (current PC)
//   imem_ack         : single-cycle completion
//   imem_rdata       : fetched word, valid with imem_ack
//   stall            : downstream cannot accept IF/ID this edge
//   branch_taken     : one-cycle redirect request
//   branch_target    : redirect PC
//   instr            : IF/ID instruction
//   opcode           : instr[31:26]
//   pc_plus4         : address of instr + PC_STEP
//   instr_valid      : IF/ID holds a real instruction
//   fetch_misalign   : sticky unaligned-branch flag (IF_ALIGN_CHECK_EN only)
//   state_dbg        : current FSM state, for observation only
//
// Build option: define IF_ALIGN_CHECK_EN to add fetch_misalign and force
// branch targets to word alignment.
// ----------------------------------------------------------------------------
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    output logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [31:0]         pc_plus4,
    output logic                instr_valid,
`ifdef IF_ALIGN_CHECK_EN
    output logic                fetch_misalign,
`endif
    output if_state_e           state_dbg
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic [31:0] redirect_q;
`ifdef IF_ALIGN_CHECK_EN
    logic        misalign_q;
`endif

    logic        ack_v;
    logic        consume;
    logic [31:0] pc_inc;
    logic [31:0] target_eff;
    logic        skid_load;
    logic        skid_drain;
    logic        skid_clear;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc_plus4;

    always_comb begin
        // An ack only counts against a request we are actually driving.
        ack_v      = imem_ack && req_q;
        consume    = valid_q && !stall;
        pc_inc     = pc_advance(pc_q, PC_STEP);
`ifdef IF_ALIGN_CHECK_EN
        target_eff = {branch_target[31:2], 2'b00};
`else
        target_eff = branch_target;
`endif
        skid_clear = branch_taken;
        skid_load  = !branch_taken && (state_q == FETCH) && ack_v && valid_q && stall;
        skid_drain = !branch_taken && (state_q == SKID) && skid_valid && consume;
    end

    if_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load_i     (skid_load),
        .drain_i    (skid_drain),
        .clear_i    (skid_clear),
        .instr_i    (imem_rdata),
        .pc_plus4_i (pc_inc),
        .valid_o    (skid_valid),
        .instr_o    (skid_instr),
        .pc_plus4_o (skid_pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
            redirect_q <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else if (branch_taken) begin
            // Redirect beats stall and ack. Whatever is in IF/ID or the
            // skid buffer belongs to the wrong path.
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            if (req_q && !ack_v) begin
                // Memory still owes us a word for the old address: keep
                // asking for it, throw it away, then jump.
                state_q    <= DRAIN;
                redirect_q <= target_eff;
            end else begin
                state_q <= FETCH;
                pc_q    <= target_eff;
            end
`ifdef IF_ALIGN_CHECK_EN
            if (branch_target[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack_v) begin
                        pc_q <= pc_inc;
                        if (!valid_q || !stall) begin
                            instr_q    <= imem_rdata;
                            pc_plus4_q <= pc_inc;
                            valid_q    <= 1'b1;
                            req_q      <= 1'b1;
                        end else begin
                            // Word parked in the skid buffer; stop fetching
                            // until IF/ID frees up.
                            state_q <= SKID;
                            req_q   <= 1'b0;
                        end
                    end else begin
                        if (consume) begin
                            valid_q <= 1'b0;
                        end
                        // Also raises req on the first cycle after reset.
                        req_q <= 1'b1;
                    end
                end
                SKID: begin
                    if (consume) begin
                        instr_q    <= skid_instr;
                        pc_plus4_q <= skid_pc_plus4;
                        valid_q    <= 1'b1;
                        state_q    <= FETCH;
                        req_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (ack_v) begin
                        pc_q    <= redirect_q;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign pc_plus4    = pc_plus4_q;
    assign instr_valid = valid_q;
    assign state_dbg   = state_q;
`ifdef IF_ALIGN_CHECK_EN
    assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed scenarios followed by a randomized run. The random run uses a
// memory that answers with a random 0..3 cycle wait and returns memf(addr);
// the reference is the program-order instruction stream: every word handed
// downstream must be memf(next expected address), the stream advances by 4
// per consumed word and restarts at the branch target on a taken branch.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    if_state_e   state_dbg;
`ifdef IF_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .opcode        (opcode),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
`ifdef IF_ALIGN_CHECK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .state_dbg     (state_dbg)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rd, input logic st,
                         input logic br, input logic [31:0] tgt);
        imem_ack      = ack;
        imem_rdata    = rd;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] w;
    logic        mem_busy;
    int          mem_wait;
    logic        r_ack, r_st, r_br, cons;
    logic [31:0] r_tgt, s_instr, s_pp4, s_addr, exp_pc, exp_w;
    logic [5:0]  s_opc;
    logic        s_req;
    int          idle, consumed;

    initial begin
        // ---------------- reset values ----------------
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req",   {31'b0, imem_req}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opc",   {26'b0, opcode}, 32'h0);
        chk("rst_pp4",   pc_plus4, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_state", {30'b0, state_dbg}, {30'b0, FETCH});
        rst = 1'b0;
        tick();
        chk("req_up", {31'b0, imem_req}, 32'h1);
        chk("req_up_addr", imem_addr, 32'h0);

        // ---------------- ack every cycle, rdata = addr ----------------
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 32'(4 * i));
            drive(1'b1, imem_addr, 1'b0, 1'b0, 32'h0);
            tick();
            w = 32'(4 * i);
            chk("seq_instr", instr, w);
            chk("seq_opc",   {26'b0, opcode}, {26'b0, w[31:26]});
            chk("seq_valid", {31'b0, instr_valid}, 32'h1);
            chk("seq_pp4",   pc_plus4, 32'(4 * i + 4));
        end

        // ---------------- stall into the skid buffer ----------------
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        drive(1'b1, 32'h8C22_0004, 1'b0, 1'b0, 32'h0);
        tick();
        chk("stl_first", instr, 32'h8C22_0004);
        chk("stl_addr4", imem_addr, 32'h4);
        drive(1'b1, 32'h2003_0005, 1'b1, 1'b0, 32'h0);
        tick();
        chk("stl_hold_instr", instr, 32'h8C22_0004);
        chk("stl_hold_opc",   {26'b0, opcode}, 32'h23);
        chk("stl_req_drop",   {31'b0, imem_req}, 32'h0);
        chk("stl_pc8",        imem_addr, 32'h8);
        chk("stl_state",      {30'b0, state_dbg}, {30'b0, SKID});
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("stl_hold2", instr, 32'h8C22_0004);
        chk("stl_req_drop2", {31'b0, imem_req}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("stl_rel_instr", instr, 32'h2003_0005);
        chk("stl_rel_opc",   {26'b0, opcode}, 32'h08);
        chk("stl_rel_pp4",   pc_plus4, 32'h8);
        chk("stl_rel_valid", {31'b0, instr_valid}, 32'h1);
        chk("stl_rel_req",   {31'b0, imem_req}, 32'h1);
        chk("stl_rel_addr",  imem_addr, 32'h8);

        // ---------------- branch while a request is pending ----------------
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        tick();
        chk("drn_valid", {31'b0, instr_valid}, 32'h0);
        chk("drn_req",   {31'b0, imem_req}, 32'h1);
        chk("drn_addr",  imem_addr, 32'h8);
        chk("drn_state", {30'b0, state_dbg}, {30'b0, DRAIN});
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
            chk("drn_wait_req",   {31'b0, imem_req}, 32'h1);
            chk("drn_wait_addr",  imem_addr, 32'h8);
            chk("drn_wait_valid", {31'b0, instr_valid}, 32'h0);
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        tick();
        chk("drn_drop_valid", {31'b0, instr_valid}, 32'h0);
        chk("drn_new_addr",   imem_addr, 32'h40);
        chk("drn_new_req",    {31'b0, imem_req}, 32'h1);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        tick();
        chk("drn_tgt_instr", instr, 32'h1234_5678);
        chk("drn_tgt_pp4",   pc_plus4, 32'h44);

        // ---------------- branch + ack + stall in one cycle ----------------
        drive(1'b1, 32'hBAD0_0000, 1'b1, 1'b1, 32'h80);
        tick();
        chk("bas_valid", {31'b0, instr_valid}, 32'h0);
        chk("bas_addr",  imem_addr, 32'h80);
        chk("bas_req",   {31'b0, imem_req}, 32'h1);
        chk("bas_state", {30'b0, state_dbg}, {30'b0, FETCH});
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0);
        tick();
        chk("bas_next_instr", instr, 32'hAAAA_0001);
        chk("bas_next_pp4",   pc_plus4, 32'h84);

        // ---------------- reset mid-wait with stall ----------------
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        chk("mrst_addr",  imem_addr, 32'h0);
        chk("mrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("mrst_opc",   {26'b0, opcode}, 32'h0);
        chk("mrst_req",   {31'b0, imem_req}, 32'h0);
        chk("mrst_instr", instr, 32'h0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // ---------------- PC wrap ----------------
        drive(1'b1, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'b0, instr_valid}, 32'h0);
        drive(1'b1, 32'h0400_0000, 1'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_pp4",   pc_plus4, 32'h0);
        chk("wrap_next",  imem_addr, 32'h0);
        chk("wrap_opc",   {26'b0, opcode}, 32'h01);

        // ---------------- unaligned branch target ----------------
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h42);
        tick();
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_addr", imem_addr, 32'h40);
        chk("mis_flag", {31'b0, fetch_misalign}, 32'h1);
`else
        chk("mis_addr_raw", imem_addr, 32'h42);
`endif
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h100);
        tick();
        chk("mis_aligned_addr", imem_addr, 32'h100);
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_sticky", {31'b0, fetch_misalign}, 32'h1);
`endif

        // ---------------- randomized stream check ----------------
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        mem_busy = 1'b0;
        mem_wait = 0;
        exp_pc   = RESET_PC_DEFAULT;
        idle     = 0;
        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            if (imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_wait = $urandom_range(0, 3);
                end
                r_ack = (mem_wait == 0);
                if (r_ack) mem_busy = 1'b0;
                else       mem_wait--;
            end else begin
                mem_busy = 1'b0;
                r_ack    = 1'b0;
            end
            r_st  = ($urandom_range(0, 9) < 3);
            r_br  = ($urandom_range(0, 24) == 0);
            r_tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                                 : (32'($urandom_range(0, 255)) << 2);
            drive(r_ack, r_ack ? memf(imem_addr) : 32'h0, r_st, r_br, r_tgt);
            cons    = instr_valid && !r_st;
            s_instr = instr;
            s_pp4   = pc_plus4;
            s_opc   = opcode;
            s_req   = imem_req;
            s_addr  = imem_addr;
            tick();
            if (cons) begin
                exp_w = memf(exp_pc);
                chk("rnd_instr", s_instr, exp_w);
                chk("rnd_pp4",   s_pp4, exp_pc + 32'd4);
                chk("rnd_opc",   {26'b0, s_opc}, {26'b0, exp_w[31:26]});
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (r_br) exp_pc = r_tgt;
            if (s_req && !r_ack) begin
                chk("rnd_req_hold",  {31'b0, imem_req}, 32'h1);
                chk("rnd_addr_hold", imem_addr, s_addr);
            end
            if (cons || r_st || r_br) idle = 0;
            else                      idle++;
            chk("rnd_progress", {31'b0, idle <= 12}, 32'h1);
            if (idle > 12) idle = 0;
        end
        chk("rnd_consumed_min", {31'b0, consumed > 300}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
